// File: rtl/fsb_pkg.sv
// Shared definitions for the external flash/static bus controller.
package fsb_pkg;

    // Access sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } fsb_state_e;

    localparam int TMO_CYC_DEF = 255;
    localparam int WAIT_W      = 7;

    // Strobe counter must hold both the 7-bit wait value and TMO_CYC-1.
    function automatic int cnt_width(input int tmo);
        int w;
        w = WAIT_W;
        while ((64'd1 << w) <= 64'(tmo)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fsb_ctrl_if.sv
// External bus pins. master = controller side, slave = device/bench side.
interface fsb_ctrl_if #(
    parameter int ADDR_W = 24
);
    logic [ADDR_W-1:0] FSB_ADRo;
    logic [7:0]        FSB_DATo;
    logic [7:0]        FSB_DATi;
    logic              FSB_OEo;
    logic              FSB_CSo;
    logic              FSB_REo;
    logic              FSB_WEo;
    logic              FSB_RDYi;

    modport master (
        output FSB_ADRo, FSB_DATo, FSB_OEo, FSB_CSo, FSB_REo, FSB_WEo,
        input  FSB_DATi, FSB_RDYi
    );

    modport slave (
        input  FSB_ADRo, FSB_DATo, FSB_OEo, FSB_CSo, FSB_REo, FSB_WEo,
        output FSB_DATi, FSB_RDYi
    );
endinterface

// File: rtl/fsb_rr_arb.sv
// Two-way round-robin arbiter. ptr_q names the master that wins a tie;
// on upd it moves to the master that was not just served.
module fsb_rr_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic upd,
    input  logic served,
    output logic gnt,
    output logic any_req
);

    logic ptr_q;
    logic ptr_d;

    // Grant: lone requester wins, a tie goes to the pointer.
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            gnt = ptr_q;
        end else begin
            gnt = req1;
        end
    end

    // Pointer update after each served access.
    always_comb begin
        ptr_d = ptr_q;
        if (upd) begin
            ptr_d = ~served;
        end
    end

    // Pointer register, resets to favour M0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fsb_ctrl.sv
// Two-master external bus controller: arbitrates CPU/DMA requests and runs
// a SETUP/STROBE/HOLD cycle on the external bus, with either fixed wait
// states (async) or a ready handshake with timeout (sync).
module fsb_ctrl
    import fsb_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SYNC_MODE,
    input  logic [6:0]        ASYNC_WAITCYCLE,
    input  logic [ADDR_W-1:0] M0_ADRi,
    input  logic [7:0]        M0_DATi,
    output logic [7:0]        M0_DATo,
    input  logic              M0_WEi,
    input  logic              M0_CYCi,
    input  logic              M0_STBi,
    output logic              M0_ACKo,
    output logic              M0_ERRo,
    input  logic [ADDR_W-1:0] M1_ADRi,
    input  logic [7:0]        M1_DATi,
    output logic [7:0]        M1_DATo,
    input  logic              M1_WEi,
    input  logic              M1_CYCi,
    input  logic              M1_STBi,
    output logic              M1_ACKo,
    output logic              M1_ERRo,
    fsb_ctrl_if.master        fsb,
    output logic              BUSY,
    output logic              GNT
);

    localparam int CNT_W = cnt_width(TMO_CYC);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TMO_CYC - 1);

    fsb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [7:0]        wdat_q, wdat_d;
    logic [7:0]        rdat_q, rdat_d;
    logic              we_q, we_d;
    logic              gnt_q, gnt_d;
    logic              sync_q, sync_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic              drop_q, drop_d;

    logic req0, req1;
    logic gnt_arb, any_req;
    logic gnt_cyc;
    logic hold_ok;

    assign req0    = M0_CYCi & M0_STBi;
    assign req1    = M1_CYCi & M1_STBi;
    assign gnt_cyc = gnt_q ? M1_CYCi : M0_CYCi;

    fsb_rr_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .upd     (state_q == ST_HOLD),
        .served  (gnt_q),
        .gnt     (gnt_arb),
        .any_req (any_req)
    );

    // Next-state: latch the whole request and config on entry so that
    // mid-access config changes only affect the following access.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        we_d    = we_q;
        gnt_d   = gnt_q;
        sync_d  = sync_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        drop_d  = drop_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_SETUP;
                    gnt_d   = gnt_arb;
                    adr_d   = gnt_arb ? M1_ADRi : M0_ADRi;
                    wdat_d  = gnt_arb ? M1_DATi : M0_DATi;
                    we_d    = gnt_arb ? M1_WEi  : M0_WEi;
                    sync_d  = SYNC_MODE;
                    cnt_d   = SYNC_MODE ? TMO_LOAD : CNT_W'(ASYNC_WAITCYCLE);
                    tmo_d   = 1'b0;
                    drop_d  = 1'b0;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                if (!gnt_cyc) drop_d = 1'b1;
            end
            ST_STROBE: begin
                if (!gnt_cyc) drop_d = 1'b1;
                if ((sync_q && fsb.FSB_RDYi) || (cnt_q == '0)) begin
                    state_d = ST_HOLD;
                    tmo_d   = sync_q && !fsb.FSB_RDYi;
                    if (!we_q) rdat_d = fsb.FSB_DATi;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus strobes and master responses decoded from the registered state.
    always_comb begin
        hold_ok      = (state_q == ST_HOLD) && !drop_q && gnt_cyc;
        BUSY         = (state_q != ST_IDLE);
        GNT          = gnt_q;
        fsb.FSB_CSo  = (state_q != ST_IDLE);
        fsb.FSB_REo  = (state_q == ST_STROBE) && !we_q;
        fsb.FSB_WEo  = (state_q == ST_STROBE) && we_q;
        fsb.FSB_OEo  = (state_q != ST_IDLE) && we_q;
        fsb.FSB_ADRo = adr_q;
        fsb.FSB_DATo = wdat_q;
        M0_ACKo      = hold_ok && !tmo_q && !gnt_q;
        M1_ACKo      = hold_ok && !tmo_q && gnt_q;
        M0_ERRo      = hold_ok && tmo_q && !gnt_q;
        M1_ERRo      = hold_ok && tmo_q && gnt_q;
        M0_DATo      = rdat_q;
        M1_DATo      = rdat_q;
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            we_q    <= 1'b0;
            gnt_q   <= 1'b0;
            sync_q  <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            we_q    <= we_d;
            gnt_q   <= gnt_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_fsb_ctrl.sv
// Directed bench for fsb_ctrl.
module tb_fsb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync_mode;
    logic [6:0]  wait_cyc;
    logic [23:0] m0_adr, m1_adr;
    logic [7:0]  m0_dati, m1_dati, m0_dato, m1_dato;
    logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
    logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
    logic        busy, gnt;

    int n_chk = 0;
    int n_err = 0;

    int n_re, n_we, n_oe, n_st;
    int n_ack_own, n_err_own, n_other;
    int ack_at, err_at;

    fsb_ctrl_if #(.ADDR_W(24)) fsb_bus ();

    fsb_ctrl #(.ADDR_W(24), .TMO_CYC(255)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .SYNC_MODE       (sync_mode),
        .ASYNC_WAITCYCLE (wait_cyc),
        .M0_ADRi         (m0_adr),
        .M0_DATi         (m0_dati),
        .M0_DATo         (m0_dato),
        .M0_WEi          (m0_we),
        .M0_CYCi         (m0_cyc),
        .M0_STBi         (m0_stb),
        .M0_ACKo         (m0_ack),
        .M0_ERRo         (m0_err),
        .M1_ADRi         (m1_adr),
        .M1_DATi         (m1_dati),
        .M1_DATo         (m1_dato),
        .M1_WEi          (m1_we),
        .M1_CYCi         (m1_cyc),
        .M1_STBi         (m1_stb),
        .M1_ACKo         (m1_ack),
        .M1_ERRo         (m1_err),
        .fsb             (fsb_bus),
        .BUSY            (busy),
        .GNT             (gnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before 1000000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_req(input bit m);
        if (!m) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
        else    begin m1_cyc = 1'b0; m1_stb = 1'b0; end
    endtask

    // One access by master m; drop_cyc/chg_cyc of 0 means unused.
    task automatic access(input bit m, input bit w, input logic [23:0] adr,
                          input logic [7:0] d, input int rdy_at, input int drop_cyc,
                          input int chg_cyc, input logic [6:0] chg_val);
        int  c;
        bit  seen, done;
        n_re = 0; n_we = 0; n_oe = 0; n_st = 0;
        n_ack_own = 0; n_err_own = 0; n_other = 0;
        ack_at = -1; err_at = -1;
        fsb_bus.FSB_DATi = d;
        fsb_bus.FSB_RDYi = 1'b0;
        if (!m) begin
            m0_adr = adr; m0_dati = d; m0_we = w; m0_cyc = 1'b1; m0_stb = 1'b1;
        end else begin
            m1_adr = adr; m1_dati = d; m1_we = w; m1_cyc = 1'b1; m1_stb = 1'b1;
        end
        c = 0; seen = 1'b0; done = 1'b0;
        while (!done && c < 400) begin
            tick();
            c++;
            fsb_bus.FSB_RDYi = 1'b0;
            if (fsb_bus.FSB_REo) n_re++;
            if (fsb_bus.FSB_WEo) n_we++;
            if (fsb_bus.FSB_OEo) n_oe++;
            if (fsb_bus.FSB_REo || fsb_bus.FSB_WEo) begin
                n_st++;
                if (rdy_at != 0 && n_st == rdy_at) fsb_bus.FSB_RDYi = 1'b1;
            end
            if (m ? m1_ack : m0_ack) begin n_ack_own++; ack_at = c; end
            if (m ? m1_err : m0_err) begin n_err_own++; err_at = c; end
            if (m ? (m0_ack | m0_err) : (m1_ack | m1_err)) n_other++;
            if ((m ? (m1_ack | m1_err) : (m0_ack | m0_err)) || c == drop_cyc) drop_req(m);
            if (c == chg_cyc) wait_cyc = chg_val;
            if (busy) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        chk("acc_done", 32'(done), 1);
        drop_req(m);
        fsb_bus.FSB_RDYi = 1'b0;
    endtask

    initial begin
        int k;
        int c;
        logic exp_m;
        rst_n = 1'b0; sync_mode = 1'b0; wait_cyc = '0;
        m0_adr = '0; m0_dati = '0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_adr = '0; m1_dati = '0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        fsb_bus.FSB_DATi = '0; fsb_bus.FSB_RDYi = 1'b0;

        // Reset values
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_cs", 32'(fsb_bus.FSB_CSo), 0);
        chk("rst_strb", 32'({fsb_bus.FSB_REo, fsb_bus.FSB_WEo, fsb_bus.FSB_OEo}), 0);
        chk("rst_ack", 32'({m0_ack, m0_err, m1_ack, m1_err}), 0);
        chk("rst_adr", 32'(fsb_bus.FSB_ADRo), 0);
        chk("rst_dato", 32'(fsb_bus.FSB_DATo), 0);
        chk("rst_rdat", 32'(m0_dato), 0);
        rst_n = 1'b1;
        tick();

        // Async read, wait 2
        wait_cyc = 7'd2;
        access(1'b0, 1'b0, 24'h001234, 8'hA5, 0, 0, 0, 7'd0);
        chk("rd_re_cycles", n_re, 3);
        chk("rd_we_cycles", n_we, 0);
        chk("rd_oe_cycles", n_oe, 0);
        chk("rd_ack", n_ack_own, 1);
        chk("rd_other", n_other, 0);
        chk("rd_ack_at", ack_at, 5);
        chk("rd_m0_dat", 32'(m0_dato), 32'hA5);
        chk("rd_m1_dat", 32'(m1_dato), 32'hA5);
        chk("rd_adr", 32'(fsb_bus.FSB_ADRo), 32'h001234);
        chk("rd_gnt", 32'(gnt), 0);

        // Async write by M1, wait 0
        wait_cyc = 7'd0;
        access(1'b1, 1'b1, 24'h00ABCD, 8'h3C, 0, 0, 0, 7'd0);
        chk("wr_we_cycles", n_we, 1);
        chk("wr_re_cycles", n_re, 0);
        chk("wr_oe_cycles", n_oe, 3);
        chk("wr_ack", n_ack_own, 1);
        chk("wr_other", n_other, 0);
        chk("wr_ack_at", ack_at, 3);
        chk("wr_dato", 32'(fsb_bus.FSB_DATo), 32'h3C);
        chk("wr_gnt", 32'(gnt), 1);
        chk("wr_rdat_held", 32'(m0_dato), 32'hA5);

        // Wait changed 5 -> 1 during strobe
        wait_cyc = 7'd5;
        access(1'b0, 1'b0, 24'h000010, 8'hC3, 0, 0, 3, 7'd1);
        chk("cfg_cur_re", n_re, 6);
        chk("cfg_cur_ack_at", ack_at, 8);
        access(1'b1, 1'b0, 24'h000020, 8'h5A, 0, 0, 0, 7'd0);
        chk("cfg_nxt_re", n_re, 2);
        chk("cfg_nxt_ack_at", ack_at, 4);
        chk("cfg_nxt_dat", 32'(m1_dato), 32'h5A);

        // Maximum wait value
        wait_cyc = 7'd127;
        access(1'b0, 1'b1, 24'hFFFFFF, 8'h81, 0, 0, 0, 7'd0);
        chk("w127_we", n_we, 128);
        chk("w127_oe", n_oe, 130);
        chk("w127_ack_at", ack_at, 130);

        // Sync mode, ready on 4th strobe cycle
        sync_mode = 1'b1;
        access(1'b1, 1'b0, 24'h000300, 8'h99, 4, 0, 0, 7'd0);
        chk("sy_re", n_re, 4);
        chk("sy_ack", n_ack_own, 1);
        chk("sy_err", n_err_own, 0);
        chk("sy_ack_at", ack_at, 6);
        chk("sy_dat", 32'(m0_dato), 32'h99);

        // Sync mode, ready never arrives
        access(1'b0, 1'b1, 24'h000400, 8'h42, 0, 0, 0, 7'd0);
        chk("tmo_we", n_we, 255);
        chk("tmo_err", n_err_own, 1);
        chk("tmo_ack", n_ack_own, 0);
        chk("tmo_err_at", err_at, 257);
        chk("tmo_other", n_other, 0);
        sync_mode = 1'b0;

        // M0 drops CYC mid-access: cycle completes, no response
        wait_cyc = 7'd1;
        access(1'b0, 1'b0, 24'h000500, 8'h77, 0, 2, 0, 7'd0);
        chk("drop_re", n_re, 2);
        chk("drop_ack", n_ack_own, 0);
        chk("drop_err", n_err_own, 0);
        chk("drop_other", n_other, 0);
        chk("drop_rdat", 32'(m0_dato), 32'h77);

        // Contention: pointer now favours M1 after serving M0
        wait_cyc = 7'd0;
        m0_we = 1'b0; m1_we = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        k = 0;
        c = 0;
        while (k < 4 && c < 40) begin
            tick();
            c++;
            if (m0_ack | m1_ack | m0_err | m1_err) begin
                exp_m = (k % 2 == 0);
                chk("cont_both", 32'(m0_ack & m1_ack), 0);
                chk("cont_ack_m1", 32'(m1_ack), 32'(exp_m));
                chk("cont_ack_m0", 32'(m0_ack), 32'(!exp_m));
                chk("cont_gnt", 32'(gnt), 32'(exp_m));
                k++;
            end
        end
        chk("cont_count", k, 4);
        drop_req(1'b0);
        drop_req(1'b1);
        c = 0;
        while (busy && c < 10) begin
            tick();
            c++;
        end
        chk("cont_idle", 32'(busy), 0);

        // Reset in the middle of a strobe
        wait_cyc = 7'd10;
        m0_adr = 24'h000600; m0_we = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
        fsb_bus.FSB_DATi = 8'h11;
        tick(); tick(); tick();
        chk("mid_re", 32'(fsb_bus.FSB_REo), 1);
        chk("mid_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_re", 32'(fsb_bus.FSB_REo), 0);
        chk("arst_cs", 32'(fsb_bus.FSB_CSo), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ack", 32'({m0_ack, m0_err, m1_ack, m1_err}), 0);
        chk("arst_adr", 32'(fsb_bus.FSB_ADRo), 0);
        chk("arst_rdat", 32'(m0_dato), 0);
        drop_req(1'b0);
        tick(); tick();
        chk("arst_hold_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();
        chk("post_idle", 32'(busy), 0);
        wait_cyc = 7'd0;
        access(1'b1, 1'b0, 24'h000700, 8'hE7, 0, 0, 0, 7'd0);
        chk("post_re", n_re, 1);
        chk("post_ack", n_ack_own, 1);
        chk("post_ack_at", ack_at, 3);
        chk("post_dat", 32'(m1_dato), 32'hE7);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
